// File: rtl/hd_transfer_controller_pkg.sv
// Shared definitions for the hard-drive transfer controller: FSM states,
// transfer direction codes and default widths.
package hd_transfer_controller_pkg;

  localparam int unsigned DEF_DATA_W            = 32;
  localparam int unsigned DEF_TRACK_W           = 7;
  localparam int unsigned DEF_SECTOR_W          = 14;
  localparam int unsigned DEF_SECTORS_PER_TRACK = 16384;
  localparam int unsigned DEF_MEM_AW            = 10;
  localparam int unsigned DEF_LEN_W             = 10;

  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE_RD,
    ST_STORE_WR,
    ST_DONE
  } state_e;

  // First state after an accepted start request.
  function automatic state_e entry_state(input logic zero_len, input logic dir);
    if (zero_len) begin
      return ST_DONE;
    end else if (dir == DIR_LOAD) begin
      return ST_LOAD;
    end else begin
      return ST_STORE_RD;
    end
  endfunction

endpackage

// File: rtl/hd_transfer_controller_address_counter.sv
// Hard-drive (track, sector) pointer: loads the first address, then steps one
// sector at a time with wrap into the next track and a sticky overflow flag.
module hd_address_counter #(
  parameter int unsigned TRACK_W           = 7,
  parameter int unsigned SECTOR_W          = 14,
  parameter int unsigned SECTORS_PER_TRACK = 16384
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic                inc_i,
  input  logic [TRACK_W-1:0]  track_i,
  input  logic [SECTOR_W-1:0] sector_i,
  output logic [TRACK_W-1:0]  track_o,
  output logic [SECTOR_W-1:0] sector_o,
  output logic                overflow_o
);

  localparam logic [SECTOR_W-1:0] LAST_SECTOR = SECTOR_W'(SECTORS_PER_TRACK - 1);

  logic [TRACK_W-1:0]  track_q,  track_d;
  logic [SECTOR_W-1:0] sector_q, sector_d;
  logic                overflow_q, overflow_d;

  always_comb begin
    track_d    = track_q;
    sector_d   = sector_q;
    overflow_d = overflow_q;
    if (load_i) begin
      track_d    = track_i;
      sector_d   = sector_i;
      overflow_d = 1'b0;
    end else if (inc_i) begin
      if (sector_q == LAST_SECTOR) begin
        sector_d = '0;
        track_d  = track_q + 1'b1;
        // Running off the last track wraps to track 0 but is remembered.
        if (track_q == '1) begin
          overflow_d = 1'b1;
        end
      end else begin
        sector_d = sector_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      track_q    <= '0;
      sector_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      track_q    <= track_d;
      sector_q   <= sector_d;
      overflow_q <= overflow_d;
    end
  end

  assign track_o    = track_q;
  assign sector_o   = sector_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/hd_transfer_controller.sv
// Initiator for word transfers between the hard drive and data memory:
// load (HD->memory, one word per cycle) or store (memory->HD, two cycles per word).
module hd_transfer_controller
  import hd_transfer_controller_pkg::*;
#(
  parameter int unsigned DATA_W            = DEF_DATA_W,
  parameter int unsigned TRACK_W           = DEF_TRACK_W,
  parameter int unsigned SECTOR_W          = DEF_SECTOR_W,
  parameter int unsigned SECTORS_PER_TRACK = DEF_SECTORS_PER_TRACK,
  parameter int unsigned MEM_AW            = DEF_MEM_AW,
  parameter int unsigned LEN_W             = DEF_LEN_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                direction,
  input  logic [TRACK_W-1:0]  req_track,
  input  logic [SECTOR_W-1:0] req_sector,
  input  logic [MEM_AW-1:0]   req_mem_addr,
  input  logic [LEN_W-1:0]    req_length,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [TRACK_W-1:0]  track,
  output logic [SECTOR_W-1:0] sector,
  output logic [DATA_W-1:0]   data_write,
  output logic                flag_write_hd,
  input  logic [DATA_W-1:0]   output_hard_drive,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [DATA_W-1:0]   mem_rdata
);

  state_e              state_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [LEN_W-1:0]    count_q;
  logic                busy_q;
  logic                done_q;
  logic                mem_we_q;
  logic                hd_we_q;
  logic                zero_len;
  logic                last_word;
  logic                addr_load;
  logic                addr_inc;

  assign zero_len  = (req_length == '0);
  assign last_word = (count_q == LEN_W'(1));
  assign addr_load = (state_q == ST_IDLE) && start;
  assign addr_inc  = (state_q == ST_LOAD) || (state_q == ST_STORE_WR);

  hd_address_counter #(
    .TRACK_W          (TRACK_W),
    .SECTOR_W         (SECTOR_W),
    .SECTORS_PER_TRACK(SECTORS_PER_TRACK)
  ) u_addr (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (addr_load),
    .inc_i     (addr_inc),
    .track_i   (req_track),
    .sector_i  (req_sector),
    .track_o   (track),
    .sector_o  (sector),
    .overflow_o(overflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      count_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_we_q   <= 1'b0;
      hd_we_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= entry_state(zero_len, direction);
            mem_addr_q <= req_mem_addr;
            count_q    <= req_length;
            busy_q     <= !zero_len;
            done_q     <= zero_len;
            mem_we_q   <= !zero_len && (direction == DIR_LOAD);
          end
        end
        ST_LOAD: begin
          mem_addr_q <= mem_addr_q + 1'b1;
          count_q    <= count_q - 1'b1;
          if (last_word) begin
            state_q  <= ST_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            mem_we_q <= 1'b0;
          end
        end
        ST_STORE_RD: begin
          state_q <= ST_STORE_WR;
          hd_we_q <= 1'b1;
        end
        ST_STORE_WR: begin
          hd_we_q    <= 1'b0;
          mem_addr_q <= mem_addr_q + 1'b1;
          count_q    <= count_q - 1'b1;
          if (last_word) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_STORE_RD;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_addr = mem_addr_q;

  // Enables are registered but masked by reset so a reset cycle never writes.
  assign mem_we        = mem_we_q & ~reset;
  assign flag_write_hd = hd_we_q & ~reset;

  // Data paths are pass-through: HD read is combinational, memory read lands
  // in STORE_WR one cycle after STORE_RD presented the address.
  assign mem_wdata  = mem_we_q ? output_hard_drive : '0;
  assign data_write = hd_we_q  ? mem_rdata         : '0;

endmodule

// File: tb/tb_hd_transfer_controller.sv
// Directed bench for hd_transfer_controller with a small HD model
// (8 sectors per track) and a synchronous-read data memory model.
module tb_hd_transfer_controller;
  import hd_transfer_controller_pkg::*;

  localparam int unsigned SPT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        direction;
  logic [6:0]  req_track;
  logic [13:0] req_sector;
  logic [9:0]  req_mem_addr;
  logic [9:0]  req_length;
  logic        busy, done, overflow;
  logic [6:0]  track;
  logic [13:0] sector;
  logic [31:0] data_write;
  logic        flag_write_hd;
  logic [31:0] output_hard_drive;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] hd  [0:1023];
  logic [31:0] mem [0:1023];
  logic        tb_hd_we, tb_mem_we;
  logic [9:0]  tb_idx;
  logic [31:0] tb_data;
  logic [9:0]  hd_idx;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned lat, hn, mn, bn;

  always #5 clock = ~clock;

  hd_transfer_controller #(
    .SECTORS_PER_TRACK(SPT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .direction        (direction),
    .req_track        (req_track),
    .req_sector       (req_sector),
    .req_mem_addr     (req_mem_addr),
    .req_length       (req_length),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .track            (track),
    .sector           (sector),
    .data_write       (data_write),
    .flag_write_hd    (flag_write_hd),
    .output_hard_drive(output_hard_drive),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_we           (mem_we),
    .mem_rdata        (mem_rdata)
  );

  assign hd_idx            = {track, 3'b000} + 10'(sector);
  assign output_hard_drive = hd[hd_idx];

  always @(posedge clock) begin
    if (flag_write_hd) hd[hd_idx] <= data_write;
    if (tb_hd_we) hd[tb_idx] <= tb_data;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (tb_mem_we) mem[tb_idx] <= tb_data;
    mem_rdata <= mem[mem_addr];
  end

  function automatic int unsigned hix(input int unsigned t, input int unsigned s);
    return t * SPT + s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke_hd(input int unsigned idx, input logic [31:0] d);
    @(negedge clock);
    tb_idx = idx[9:0]; tb_data = d; tb_hd_we = 1'b1;
    @(negedge clock);
    tb_hd_we = 1'b0;
  endtask

  task automatic poke_mem(input int unsigned idx, input logic [31:0] d);
    @(negedge clock);
    tb_idx = idx[9:0]; tb_data = d; tb_mem_we = 1'b1;
    @(negedge clock);
    tb_mem_we = 1'b0;
  endtask

  // Issue one request and sample every cycle until done or the budget runs out.
  // lat is the cycle (after the start cycle) in which done was seen, 0 if never.
  task automatic run_xfer(input logic dir, input int unsigned trk, input int unsigned sec,
                          input int unsigned maddr, input int unsigned len,
                          input int unsigned pulse_at,
                          output int unsigned o_lat, output int unsigned o_hn,
                          output int unsigned o_mn, output int unsigned o_bn);
    o_lat = 0; o_hn = 0; o_mn = 0; o_bn = 0;
    @(negedge clock);
    direction    = dir;
    req_track    = 7'(trk);
    req_sector   = 14'(sec);
    req_mem_addr = 10'(maddr);
    req_length   = 10'(len);
    start        = 1'b1;
    for (int unsigned k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (flag_write_hd) o_hn++;
      if (mem_we) o_mn++;
      if (busy) o_bn++;
      start = (k == pulse_at);
      if (k == pulse_at) begin
        direction    = ~dir;
        req_track    = 7'd99;
        req_sector   = 14'd3;
        req_mem_addr = 10'h3FF;
        req_length   = 10'd1;
      end
      if (done) begin
        o_lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; direction = DIR_LOAD;
    req_track = '0; req_sector = '0; req_mem_addr = '0; req_length = '0;
    tb_hd_we = 1'b0; tb_mem_we = 1'b0; tb_idx = '0; tb_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_track", 32'(track), 32'd0);
    check("rst_sector", 32'(sector), 32'd0);
    check("rst_maddr", 32'(mem_addr), 32'd0);
    check("rst_we", {30'd0, mem_we, flag_write_hd}, 32'd0);
    check("rst_wdata", mem_wdata | data_write, 32'd0);

    // Load 4 words from (3,5); crosses into (4,0).
    poke_hd(hix(3, 5), 32'hA0); poke_hd(hix(3, 6), 32'hA1);
    poke_hd(hix(3, 7), 32'hA2); poke_hd(hix(4, 0), 32'hA3);
    run_xfer(DIR_LOAD, 3, 5, 'h010, 4, 0, lat, hn, mn, bn);
    check("ld_latency", lat, 5);
    check("ld_hd_we", hn, 0);
    check("ld_mem_we", mn, 4);
    check("ld_busy", bn, 4);
    check("ld_track", 32'(track), 4);
    check("ld_sector", 32'(sector), 1);
    @(negedge clock);
    check("ld_done_pulse", 32'(done), 0);
    check("ld_mem0", mem['h010], 32'hA0);
    check("ld_mem1", mem['h011], 32'hA1);
    check("ld_mem2", mem['h012], 32'hA2);
    check("ld_mem3", mem['h013], 32'hA3);

    // Store 3 words to (0,0..2).
    poke_mem('h020, 32'h11); poke_mem('h021, 32'h22); poke_mem('h022, 32'h33);
    run_xfer(DIR_STORE, 0, 0, 'h020, 3, 0, lat, hn, mn, bn);
    check("st_latency", lat, 7);
    check("st_mem_we", mn, 0);
    check("st_hd_we", hn, 3);
    check("st_busy", bn, 6);
    @(negedge clock);
    check("st_hd0", hd[hix(0, 0)], 32'h11);
    check("st_hd1", hd[hix(0, 1)], 32'h22);
    check("st_hd2", hd[hix(0, 2)], 32'h33);

    // Store across the sector wrap (1,7) -> (2,0).
    poke_mem('h030, 32'hC0); poke_mem('h031, 32'hC1);
    run_xfer(DIR_STORE, 1, 7, 'h030, 2, 0, lat, hn, mn, bn);
    check("wrap_latency", lat, 5);
    check("wrap_ovf", 32'(overflow), 0);
    @(negedge clock);
    check("wrap_hd_1_7", hd[hix(1, 7)], 32'hC0);
    check("wrap_hd_2_0", hd[hix(2, 0)], 32'hC1);

    // Load from the last sector of the last track: second word from (0,0).
    poke_hd(hix(127, 7), 32'hB0); poke_hd(hix(0, 0), 32'hB1);
    run_xfer(DIR_LOAD, 127, 7, 'h040, 2, 0, lat, hn, mn, bn);
    check("ovf_latency", lat, 3);
    check("ovf_flag", 32'(overflow), 1);
    repeat (3) @(negedge clock);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_mem0", mem['h040], 32'hB0);
    check("ovf_mem1", mem['h041], 32'hB1);

    // Zero length: immediate done, no enables, overflow cleared by the start.
    run_xfer(DIR_STORE, 5, 1, 'h100, 0, 0, lat, hn, mn, bn);
    check("zero_latency", lat, 1);
    check("zero_enables", hn + mn, 0);
    check("zero_busy", bn, 0);
    check("zero_ovf_clr", 32'(overflow), 0);

    // Start pulsed while busy with a different request must be ignored.
    poke_hd(hix(10, 0), 32'hD0); poke_hd(hix(10, 1), 32'hD1); poke_hd(hix(10, 2), 32'hD2);
    poke_mem('h3FF, 32'hEE);
    run_xfer(DIR_LOAD, 10, 0, 'h050, 3, 1, lat, hn, mn, bn);
    check("ign_latency", lat, 4);
    check("ign_hd_we", hn, 0);
    check("ign_track", 32'(track), 10);
    check("ign_sector", 32'(sector), 3);
    @(negedge clock);
    check("ign_mem0", mem['h050], 32'hD0);
    check("ign_mem2", mem['h052], 32'hD2);
    check("ign_untouched", mem['h3FF], 32'hEE);
    check("ign_idle", 32'(busy), 0);

    // Reset during word 1 of a 4-word store.
    poke_mem('h060, 32'hE0); poke_mem('h061, 32'hE1);
    poke_mem('h062, 32'hE2); poke_mem('h063, 32'hE3);
    poke_hd(hix(20, 0), 32'h5A00); poke_hd(hix(20, 1), 32'h5A01);
    poke_hd(hix(20, 3), 32'h5A03);
    @(negedge clock);
    direction = DIR_STORE; req_track = 7'd20; req_sector = 14'd0;
    req_mem_addr = 10'h060; req_length = 10'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("rs_word0_we", 32'(flag_write_hd), 1);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rs_no_we_in_reset", {30'd0, mem_we, flag_write_hd}, 0);
    @(negedge clock);
    check("rs_busy", 32'(busy), 0);
    check("rs_hd_we", 32'(flag_write_hd), 0);
    check("rs_track", 32'(track), 0);
    check("rs_sector", 32'(sector), 0);
    reset = 1'b0;
    @(negedge clock);
    check("rs_hd_word0", hd[hix(20, 0)], 32'hE0);
    check("rs_hd_word1", hd[hix(20, 1)], 32'h5A01);

    // Fresh store after the reset completes normally.
    run_xfer(DIR_STORE, 20, 3, 'h063, 1, 0, lat, hn, mn, bn);
    check("rs_fresh_latency", lat, 3);
    @(negedge clock);
    check("rs_fresh_hd", hd[hix(20, 3)], 32'hE3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
